// File: rtl/cmp_rgb_pwm_pkg.sv
// cmp_rgb_pkg: shared types and constants for the RGB compare-to-colour block.
//   state_t    : handshake/compare FSM states
//   cmp_code_t : committed comparison result encoding
//   COL_*      : 3-bit {R,G,B} colour patterns, plus colour_of() lookup
package cmp_rgb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CMP_NONE = 2'b00,
    CMP_GT   = 2'b01,
    CMP_EQ   = 2'b10,
    CMP_LT   = 2'b11
  } cmp_code_t;

  localparam logic [2:0] COL_DARK = 3'b000;
  localparam logic [2:0] COL_GT   = 3'b101;  // magenta
  localparam logic [2:0] COL_EQ   = 3'b110;  // yellow
  localparam logic [2:0] COL_LT   = 3'b011;  // cyan

  function automatic logic [2:0] colour_of(input cmp_code_t code);
    logic [2:0] col;
    col = COL_DARK;
    unique case (code)
      CMP_GT:  col = COL_GT;
      CMP_EQ:  col = COL_EQ;
      CMP_LT:  col = COL_LT;
      default: col = COL_DARK;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/cmp_rgb_pwm_rgb_pwm.sv
// rgb_pwm: shared-duty PWM brightness gate for the three LED channels.
//   clk, rst_n        : clock, synchronous active-low reset
//   duty[PWM_BITS-1:0]: on-time per 2^PWM_BITS-cycle period, sampled every cycle
//   colour[2:0]       : {R,G,B} enable pattern
//   red, green, blue  : registered, PWM-gated LED drives (active-high)
module rgb_pwm #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] duty,
  input  logic [2:0]          colour,
  output logic                red,
  output logic                green,
  output logic                blue
);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_on_d;

  // Strict less-than: duty=0 never lights, all-ones lights all but one slot.
  assign pwm_on_d = (pwm_cnt < duty);

  // Stage p0 -> p1: counter advance and registered gating of colour by pwm_on.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      red     <= 1'b0;
      green   <= 1'b0;
      blue    <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      red     <= colour[2] & pwm_on_d;
      green   <= colour[1] & pwm_on_d;
      blue    <= colour[0] & pwm_on_d;
    end
  end

endmodule

// File: rtl/cmp_rgb_pwm.sv
// cmp_rgb_pwm: handshaked magnitude comparator driving a PWM-dimmed RGB LED.
//   clk, rst_n     : clock, synchronous active-low reset
//   in_valid/ready : operand handshake; a, b [WIDTH-1:0] captured on accept
//   duty           : LED on-time per PWM period [PWM_BITS-1:0]
//   out_valid      : one-cycle pulse when cmp_code/colour are committed
//   cmp_code[1:0]  : 00 none, 01 A>B, 10 A==B, 11 A<B (held until next result)
//   red/green/blue : PWM-gated colour outputs
// Build option: define CMP_SIGNED_EN for two's-complement comparison.
module cmp_rgb_pwm #(
  parameter int WIDTH    = 4,
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [PWM_BITS-1:0] duty,
  output logic                out_valid,
  output logic [1:0]          cmp_code,
  output logic                red,
  output logic                green,
  output logic                blue
);
  import cmp_rgb_pkg::*;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  cmp_code_t        cmp_res;
  logic [2:0]       colour;

  function automatic cmp_code_t compare(input logic [WIDTH-1:0] x,
                                        input logic [WIDTH-1:0] y);
    cmp_code_t r;
`ifdef CMP_SIGNED_EN
    logic signed [WIDTH-1:0] sx;
    logic signed [WIDTH-1:0] sy;
    sx = $signed(x);
    sy = $signed(y);
    if (sx > sy)       r = CMP_GT;
    else if (sx == sy) r = CMP_EQ;
    else               r = CMP_LT;
`else
    if (x > y)         r = CMP_GT;
    else if (x == y)   r = CMP_EQ;
    else               r = CMP_LT;
`endif
    return r;
  endfunction

  // Stage p0: operand capture on accept. Stage p1: registered compare.
  // Data registers carry no reset; an in-flight pair is dropped by the FSM.
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      op_a <= a;
      op_b <= b;
    end
    if (state == S_CMP) begin
      cmp_res <= compare(op_a, op_b);
    end
  end

  // Stage p2: control FSM and commit of result/colour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cmp_code  <= CMP_NONE;
      colour    <= COL_DARK;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            state    <= S_CMP;
            in_ready <= 1'b0;
          end
        end
        S_CMP: begin
          state <= S_DONE;
        end
        S_DONE: begin
          cmp_code  <= cmp_res;
          colour    <= colour_of(cmp_res);
          out_valid <= 1'b1;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  rgb_pwm #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk   (clk),
    .rst_n (rst_n),
    .duty  (duty),
    .colour(colour),
    .red   (red),
    .green (green),
    .blue  (blue)
  );

endmodule

// File: tb/tb_cmp_rgb_pwm.sv
// Self-checking bench for cmp_rgb_pwm with WIDTH=4, PWM_BITS=4.
module tb_cmp_rgb_pwm;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] duty;
  logic       out_valid;
  logic [1:0] cmp_code;
  logic       red;
  logic       green;
  logic       blue;

  int n_checks = 0;
  int n_errors = 0;

  // Reference PWM phase: count value after the most recent edge.
  logic [3:0] m_cnt;

  cmp_rgb_pwm #(
    .WIDTH   (4),
    .PWM_BITS(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .duty     (duty),
    .out_valid(out_valid),
    .cmp_code (cmp_code),
    .red      (red),
    .green    (green),
    .blue     (blue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) m_cnt <= 4'd0;
    else        m_cnt <= m_cnt + 4'd1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_code(input logic [3:0] x, input logic [3:0] y);
`ifdef CMP_SIGNED_EN
    if ($signed(x) > $signed(y))      return 2'b01;
    else if (x == y)                  return 2'b10;
    else                              return 2'b11;
`else
    if (x > y)                        return 2'b01;
    else if (x == y)                  return 2'b10;
    else                              return 2'b11;
`endif
  endfunction

  function automatic logic [2:0] exp_col(input logic [1:0] code);
    case (code)
      2'b01:   return 3'b101;
      2'b10:   return 3'b110;
      2'b11:   return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  // One full transaction; assumes duty=4'hF and block idle on entry.
  task automatic run_pair(input logic [3:0] xa, input logic [3:0] xb, input logic [1:0] code);
    logic [2:0] col;
    col = exp_col(code);
    chk("rdy_pre", 32'(in_ready), 32'd1);
    a = xa; b = xb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rdy_busy", 32'(in_ready), 32'd0);
    chk("ov_n0", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("ov_n1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("ov_n2", 32'(out_valid), 32'd1);
    chk("code", 32'(cmp_code), 32'(code));
    chk("rdy_back", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("ov_n3", 32'(out_valid), 32'd0);
    chk("code_hold", 32'(cmp_code), 32'(code));
    chk("rgb", 32'({red, green, blue}), (m_cnt != 4'd0) ? 32'(col) : 32'd0);
  endtask

  initial begin
    int cnt_r;
    int cnt_g;
    int cnt_b;
    int cnt_any;

    rst_n = 1'b0; in_valid = 1'b1; a = 4'd1; b = 4'd0; duty = 4'hF;

    // Reset held with in_valid asserted.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_rdy", 32'(in_ready), 32'd1);
      chk("rst_code", 32'(cmp_code), 32'd0);
      chk("rst_ov", 32'(out_valid), 32'd0);
      chk("rst_rgb", 32'({red, green, blue}), 32'd0);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;

    // All operand pairs.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        run_pair(4'(ia), 4'(ib), exp_code(4'(ia), 4'(ib)));
      end
    end

    // Sign-sensitive vector.
`ifdef CMP_SIGNED_EN
    run_pair(4'hF, 4'h1, 2'b11);
`else
    run_pair(4'hF, 4'h1, 2'b01);
`endif

    // Backpressure: a second request while busy is ignored.
    a = 4'd2; b = 4'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 4'd3; b = 4'd9;
    chk("bp_rdy", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_ov1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("bp_ov2", 32'(out_valid), 32'd1);
    chk("bp_code", 32'(cmp_code), 32'b10);
    @(posedge clk); #1;
    chk("bp_ov3", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("bp_ov4", 32'(out_valid), 32'd0);
    chk("bp_hold", 32'(cmp_code), 32'b10);
    run_pair(4'd9, 4'd3, 2'b01);

    // PWM duty=4 with colour EQ.
    run_pair(4'd5, 4'd5, 2'b10);
    duty = 4'd4;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cnt_r = 0; cnt_g = 0; cnt_b = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      cnt_r += int'(red);
      cnt_g += int'(green);
      cnt_b += int'(blue);
    end
    chk("pwm4_r", 32'(cnt_r), 32'd4);
    chk("pwm4_g", 32'(cnt_g), 32'd4);
    chk("pwm4_b", 32'(cnt_b), 32'd0);

    duty = 4'd0;
    @(posedge clk); #1;
    cnt_any = 0;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      cnt_any += int'(red) + int'(green) + int'(blue);
    end
    chk("pwm0_dark", 32'(cnt_any), 32'd0);

    // Mid-operation reset discards the pair.
    duty = 4'hF;
    @(posedge clk); #1;
    a = 4'd5; b = 4'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mr_ov", 32'(out_valid), 32'd0);
    chk("mr_code", 32'(cmp_code), 32'd0);
    chk("mr_rdy", 32'(in_ready), 32'd1);
    chk("mr_rgb", 32'({red, green, blue}), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("mr_ov_after", 32'(out_valid), 32'd0);
      chk("mr_code_after", 32'(cmp_code), 32'd0);
      chk("mr_rgb_after", 32'({red, green, blue}), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
